calc_job_sequencer: RTL and testbench
=====================================

// Module: calc_job_sequencer
// PURPOSE
//  Sequences the single-cycle ARM core as a calculator job engine. Accepts one job
//  (num1, num2, op) over a valid/ready handshake, holds the core in reset, writes the
//  operand mailbox into data RAM, releases the core, captures its store to the result
//  address, re-parks the core in reset and returns the result. Owns the data-RAM write
//  port mux between itself and the core; sits between the host side and arm + data RAM.
// PARAMETERS
//  MBOX_BASE      32'h100  mailbox base: num1 @+0, num2 @+4, op @+8
//  RESULT_ADDR    32'h200  core store to this address completes the job
//  RESET_CYCLES   3        cycles cpu_reset is held after mailbox load (>=1)
//  TIMEOUT_CYCLES 100      max RUN cycles before abort (>=1, < 2**CNT_W)
//  CNT_W          8        width of cycle counter and res_cycles
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-low
//  job_valid    in   1      job offered
//  job_ready    out  1      sequencer can accept a job
//  job_num1     in   32     operand 1
//  job_num2     in   32     operand 2
//  job_op       in   2      0 ADD, 1 SUB, 2 AND, 3 ORR
//  res_valid    out  1      result available
//  res_ready    in   1      consumer takes result
//  res_data     out  32     result, 32'hFFFFFFFF on timeout
//  res_timeout  out  1      job aborted by timeout
//  res_cycles   out  CNT_W  RUN cycles consumed by the job
//  cpu_reset    out  1      active-high reset to arm core
//  cpu_memwrite in   1      core MemWrite
//  cpu_addr     in   32     core ALUResult (data address)
//  cpu_wdata    in   32     core WriteData
//  mem_we       out  1      data RAM write enable
//  mem_addr     out  32     data RAM address
//  mem_wdata    out  32     data RAM write data
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - reset low: state=IDLE, job_ready=0, res_valid=0, res_timeout=0, res_data=0,
//    res_cycles=0, cpu_reset=1, mem_we=0, counters=0. Abort mid-job: no further RAM write.
//  - States IDLE, LOAD0, LOAD1, LOAD2, RST_HOLD, RUN, DONE; all outputs registered or
//    decoded from state only (no comb path job_valid->job_ready).
//  - IDLE: job_ready=1, cpu_reset=1. job_valid&job_ready: latch operands -> LOAD0.
//  - LOAD0/1/2: one cycle each, mem_we=1, addr MBOX_BASE+0/+4/+8, data num1/num2/
//    {30'b0,op}. cpu_reset=1 throughout.
//  - RST_HOLD: cpu_reset=1 for RESET_CYCLES cycles, mem_we=0, then -> RUN.
//  - RUN: cpu_reset=0; mem_we/addr/wdata = cpu_memwrite/cpu_addr/cpu_wdata passthrough.
//    Counter increments every RUN cycle from 1. On cycle with cpu_memwrite &
//    cpu_addr==RESULT_ADDR: store still passes to RAM that cycle; latch res_data=cpu_wdata,
//    res_cycles=counter, res_timeout=0 -> DONE. Else if counter==TIMEOUT_CYCLES:
//    res_data=32'hFFFFFFFF, res_timeout=1, res_cycles=TIMEOUT_CYCLES -> DONE. Result
//    store on the timeout cycle wins (not a timeout).
//  - DONE: cpu_reset=1, mem_we=0, res_valid=1; outputs stable until res_ready; on
//    res_valid&res_ready -> IDLE, res_valid=0 next cycle. No new job accepted in DONE.
//  - mem_addr/mem_wdata outside LOAD*/RUN = 0. Latency: accept -> core released
//    3+RESET_CYCLES cycles; result store -> res_valid next cycle.
// TESTING
//  - 5,3,op0 with core+RAM -> mailbox 0x100/104/108 = 5/3/0, res_data=8, res_timeout=0.
//  - 10,3,op1 -> 7; 12,10,op2 -> 8; 12,3,op3 -> 15, back-to-back jobs, busy drops between.
//  - core stub never writes 0x200 -> res_valid after 100 RUN cycles, res_data=FFFFFFFF,
//    res_timeout=1, res_cycles=100.
//  - res_ready held low 10 cycles in DONE -> res_valid/data stable, job_ready=0, cpu_reset=1.
//  - reset low during RUN -> next cycle cpu_reset=1, mem_we=0, res_valid=0, IDLE after.
//  - job_valid high during LOAD1 -> ignored, job_ready=0, captured operands unchanged.

Source files
------------

// File: rtl/calc_job_sequencer.sv
// Calculator job sequencer: loads an operand mailbox into data RAM, runs the ARM core
// out of reset until it stores to RESULT_ADDR (or times out), then returns the result.
module calc_job_sequencer #(
    parameter logic [31:0] MBOX_BASE      = 32'h0000_0100,
    parameter logic [31:0] RESULT_ADDR    = 32'h0000_0200,
    parameter int          RESET_CYCLES   = 3,
    parameter int          TIMEOUT_CYCLES = 100,
    parameter int          CNT_W          = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [31:0]      job_num1,
    input  logic [31:0]      job_num2,
    input  logic [1:0]       job_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_timeout,
    output logic [CNT_W-1:0] res_cycles,
    output logic             cpu_reset,
    input  logic             cpu_memwrite,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD0    = 3'd1,
        LOAD1    = 3'd2,
        LOAD2    = 3'd3,
        RST_HOLD = 3'd4,
        RUN      = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [31:0]      num1_r;
    logic [31:0]      num2_r;
    logic [1:0]       op_r;
    logic             job_ready_r;
    logic             res_valid_r;
    logic             res_timeout_r;
    logic [31:0]      res_data_r;
    logic [CNT_W-1:0] res_cycles_r;
    logic             accept_s;
    logic             result_hit_s;
    logic             timeout_hit_s;
    logic             mem_we_s;
    logic [31:0]      mem_addr_s;
    logic [31:0]      mem_wdata_s;

    assign accept_s      = (state_r == IDLE) && job_valid && job_ready_r;
    assign result_hit_s  = (state_r == RUN) && cpu_memwrite && (cpu_addr == RESULT_ADDR);
    assign timeout_hit_s = (state_r == RUN) && (cnt_r == TIMEOUT_LAST);

    // Next-state and shared cycle counter (reset-hold length, then RUN cycle number)
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = LOAD0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD0: state_next_s = LOAD1;
            LOAD1: state_next_s = LOAD2;
            LOAD2: begin
                state_next_s = RST_HOLD;
                cnt_next_s   = CNT_ONE;
            end
            RST_HOLD: begin
                if (cnt_r >= RESET_LAST) begin
                    state_next_s = RUN;
                    cnt_next_s   = CNT_ONE;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            RUN: begin
                if (result_hit_s || timeout_hit_s) begin
                    state_next_s = DONE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            DONE: begin
                if (res_valid_r && res_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // State, handshake flags and latched operands
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            job_ready_r <= 1'b0;
            res_valid_r <= 1'b0;
            num1_r      <= 32'h0000_0000;
            num2_r      <= 32'h0000_0000;
            op_r        <= 2'b00;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            job_ready_r <= (state_next_s == IDLE);
            res_valid_r <= (state_next_s == DONE);
            if (accept_s) begin
                num1_r <= job_num1;
                num2_r <= job_num2;
                op_r   <= job_op;
            end
        end
    end

    // Result capture; a result store on the timeout cycle takes priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_data_r    <= 32'h0000_0000;
            res_timeout_r <= 1'b0;
            res_cycles_r  <= CNT_ZERO;
        end else if (result_hit_s) begin
            res_data_r    <= cpu_wdata;
            res_timeout_r <= 1'b0;
            res_cycles_r  <= cnt_r;
        end else if (timeout_hit_s) begin
            res_data_r    <= 32'hFFFF_FFFF;
            res_timeout_r <= 1'b1;
            res_cycles_r  <= TIMEOUT_LAST;
        end
    end

    // Data-RAM write port mux: mailbox writes, then core passthrough while it runs
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = 32'h0000_0000;
        mem_wdata_s = 32'h0000_0000;
        case (state_r)
            LOAD0: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = MBOX_BASE;
                mem_wdata_s = num1_r;
            end
            LOAD1: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = MBOX_BASE + 32'd4;
                mem_wdata_s = num2_r;
            end
            LOAD2: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = MBOX_BASE + 32'd8;
                mem_wdata_s = {30'b0, op_r};
            end
            RUN: begin
                mem_we_s    = cpu_memwrite;
                mem_addr_s  = cpu_addr;
                mem_wdata_s = cpu_wdata;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_addr_s  = 32'h0000_0000;
                mem_wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // No RAM write may slip through while the sequencer is being reset mid-job
    assign mem_we      = mem_we_s & reset;
    assign mem_addr    = mem_addr_s;
    assign mem_wdata   = mem_wdata_s;
    assign cpu_reset   = (state_r != RUN);
    assign busy        = (state_r != IDLE);
    assign job_ready   = job_ready_r;
    assign res_valid   = res_valid_r;
    assign res_data    = res_data_r;
    assign res_timeout = res_timeout_r;
    assign res_cycles  = res_cycles_r;

endmodule

// File: tb/tb_calc_job_sequencer.sv
// Bench for calc_job_sequencer: behavioural core stub + data-RAM capture, table-driven
// jobs checked through a scoreboard, plus hand-written stall/ignore/abort sequences.
module tb_calc_job_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_num1 = 32'd0;
    logic [31:0] job_num2 = 32'd0;
    logic [1:0]  job_op = 2'd0;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_timeout;
    logic [7:0]  res_cycles;
    logic        cpu_reset;
    logic        cpu_memwrite;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;

    calc_job_sequencer dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_num1(job_num1), .job_num2(job_num2), .job_op(job_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_timeout(res_timeout), .res_cycles(res_cycles),
        .cpu_reset(cpu_reset), .cpu_memwrite(cpu_memwrite),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        timeout;
        logic [7:0]  cycles;
    } exp_t;

    typedef struct {
        logic [31:0] n1;
        logic [31:0] n2;
        logic [1:0]  op;
        int          delay;
        logic [31:0] exp_data;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_pass = 0;
    int          stub_mode = 1;
    int          stub_delay = 4;
    int          run_cnt = 0;
    logic [31:0] mb0, mb1, mb2, res_mem;

    function automatic logic [31:0] calc(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Data RAM: remember mailbox words and the last result store
    always @(posedge clk) begin
        if (mem_we) begin
            case (mem_addr)
                32'h100: mb0 <= mem_wdata;
                32'h104: mb1 <= mem_wdata;
                32'h108: mb2 <= mem_wdata;
                32'h200: res_mem <= mem_wdata;
                default: ;
            endcase
        end
    end

    // Cycles the core has been out of reset (0 on its first running cycle)
    always @(posedge clk) run_cnt <= cpu_reset ? 0 : run_cnt + 1;

    // Core stub: mode 1 reads the mailbox and stores the result at RUN cycle stub_delay,
    // mode 2 keeps storing elsewhere and never completes
    always_comb begin
        cpu_memwrite = 1'b0;
        cpu_addr     = 32'h0;
        cpu_wdata    = 32'h0;
        if (!cpu_reset && stub_mode == 1) begin
            if (run_cnt == stub_delay - 1) begin
                cpu_memwrite = 1'b1;
                cpu_addr     = 32'h200;
                cpu_wdata    = calc(mb0, mb1, mb2[1:0]);
            end else if (run_cnt == 0) begin
                cpu_memwrite = 1'b1;
                cpu_addr     = 32'h300;
                cpu_wdata    = 32'hDEAD_BEEF;
            end else begin
                cpu_addr     = 32'h200;
                cpu_wdata    = 32'h1234_5678;
            end
        end else if (!cpu_reset && stub_mode == 2) begin
            cpu_memwrite = run_cnt[0];
            cpu_addr     = run_cnt[0] ? 32'h300 : 32'h200;
            cpu_wdata    = 32'h5555_AAAA;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Offer a job at a negedge; returns at the negedge after acceptance (LOAD0)
    task automatic send_job(input logic [31:0] n1, input logic [31:0] n2, input logic [1:0] op);
        int k = 0;
        while (!job_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("job_ready_wait", {63'd0, job_ready}, 64'd1);
        job_valid = 1'b1;
        job_num1  = n1;
        job_num2  = n2;
        job_op    = op;
        @(posedge clk);
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    // Wait for a result, compare against the scoreboard head, then let it drain
    task automatic collect(input string tag, input bit chk_gap);
        exp_t e;
        int   k  = 0;
        int   ks = -1000;
        while (!res_valid && k < 200) begin
            if (!cpu_reset && cpu_memwrite && cpu_addr == 32'h200) ks = k;
            @(negedge clk);
            k++;
        end
        check({tag, "_res_valid"}, {63'd0, res_valid}, 64'd1);
        if (res_valid) begin
            if (sb_q.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check({tag, "_data"}, {32'd0, res_data}, {32'd0, e.data});
                check({tag, "_timeout"}, {63'd0, res_timeout}, {63'd0, e.timeout});
                check({tag, "_cycles"}, {56'd0, res_cycles}, {56'd0, e.cycles});
                if (!e.timeout) begin
                    check({tag, "_ram_result"}, {32'd0, res_mem}, {32'd0, e.data});
                    if (chk_gap) check({tag, "_store_to_valid"}, 64'(k - ks), 64'd1);
                end
            end
            res_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_busy_drop"}, {63'd0, busy}, 64'd0);
            check({tag, "_valid_drop"}, {63'd0, res_valid}, 64'd0);
        end
    endtask

    initial begin
        int k;
        vecs[0] = '{32'd5, 32'd3, 2'd0, 4, 32'd8};
        vecs[1] = '{32'd10, 32'd3, 2'd1, 7, 32'd7};
        vecs[2] = '{32'd12, 32'd10, 2'd2, 2, 32'd8};
        vecs[3] = '{32'd12, 32'd3, 2'd3, 9, 32'd15};
        vecs[4] = '{32'hFFFF_FFFF, 32'd1, 2'd0, 1, 32'd0};
        vecs[5] = '{32'd1, 32'd2, 2'd1, 100, 32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        check("rst_job_ready", {63'd0, job_ready}, 64'd0);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_res_data", {32'd0, res_data}, 64'd0);
        check("rst_res_cycles", {56'd0, res_cycles}, 64'd0);
        check("rst_res_timeout", {63'd0, res_timeout}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_job_ready", {63'd0, job_ready}, 64'd1);
        check("idle_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("idle_mem_wdata", {32'd0, mem_wdata}, 64'd0);

        // Back-to-back table jobs (last two: first-cycle store and store on timeout cycle)
        for (int i = 0; i < 6; i++) begin
            stub_mode  = 1;
            stub_delay = vecs[i].delay;
            send_job(vecs[i].n1, vecs[i].n2, vecs[i].op);
            sb_q.push_back('{vecs[i].exp_data, 1'b0, 8'(vecs[i].delay)});
            if (i == 0) begin
                k = 0;
                while (cpu_reset && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check("release_latency", 64'(k), 64'd6);
            end
            collect($sformatf("job%0d", i), 1'b1);
            check($sformatf("job%0d_mb0", i), {32'd0, mb0}, {32'd0, vecs[i].n1});
            check($sformatf("job%0d_mb1", i), {32'd0, mb1}, {32'd0, vecs[i].n2});
            check($sformatf("job%0d_mb2", i), {32'd0, mb2}, {62'd0, vecs[i].op});
        end

        // Core never completes -> timeout after 100 RUN cycles
        stub_mode = 2;
        send_job(32'd7, 32'd7, 2'd0);
        sb_q.push_back('{32'hFFFF_FFFF, 1'b1, 8'd100});
        collect("timeout", 1'b0);

        // Consumer stalls 10 cycles in DONE while a new job is offered
        stub_mode  = 1;
        stub_delay = 3;
        send_job(32'd20, 32'd5, 2'd1);
        sb_q.push_back('{32'd15, 1'b0, 8'd3});
        res_ready = 1'b0;
        k = 0;
        while (!res_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("stall_reach_done", {63'd0, res_valid}, 64'd1);
        job_valid = 1'b1;
        job_num1  = 32'd99;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_res_valid", {63'd0, res_valid}, 64'd1);
            check("stall_res_data", {32'd0, res_data}, 64'd15);
            check("stall_job_ready", {63'd0, job_ready}, 64'd0);
            check("stall_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        end
        job_valid = 1'b0;
        collect("stall", 1'b0);

        // job_valid during LOAD1 must not disturb the captured operands
        stub_delay = 5;
        send_job(32'd100, 32'd58, 2'd0);
        sb_q.push_back('{32'd158, 1'b0, 8'd5});
        check("load0_addr", {32'd0, mem_addr}, 64'h100);
        check("load0_wdata", {32'd0, mem_wdata}, 64'd100);
        @(negedge clk);
        job_valid = 1'b1;
        job_num1  = 32'd1;
        job_num2  = 32'd1;
        job_op    = 2'd3;
        check("load1_job_ready", {63'd0, job_ready}, 64'd0);
        check("load1_addr", {32'd0, mem_addr}, 64'h104);
        check("load1_wdata", {32'd0, mem_wdata}, 64'd58);
        @(negedge clk);
        job_valid = 1'b0;
        check("load2_addr", {32'd0, mem_addr}, 64'h108);
        check("load2_wdata", {32'd0, mem_wdata}, 64'd0);
        collect("ignore", 1'b1);

        // Reset in the middle of RUN aborts the job
        stub_mode = 2;
        send_job(32'd1, 32'd1, 2'd0);
        k = 0;
        while (cpu_reset && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("abort_in_run", {63'd0, cpu_reset}, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("abort_cpu_reset", {63'd0, cpu_reset}, 64'd1);
        check("abort_mem_we", {63'd0, mem_we}, 64'd0);
        check("abort_res_valid", {63'd0, res_valid}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_job_ready", {63'd0, job_ready}, 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_idle_ready", {63'd0, job_ready}, 64'd1);

        // Recovery job after the abort
        stub_mode  = 1;
        stub_delay = 2;
        send_job(32'd6, 32'd9, 2'd3);
        sb_q.push_back('{32'd15, 1'b0, 8'd2});
        collect("recover", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
